// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide engine:
//   - ITER      : CALC iterations per operation (one bit per cycle)
//   - OP_MUL/OP_DIV : encodings of the op input
//   - state_t and the FSM state constants IDLE/PREP/CALC/FIX/DONE
//   - cond_neg  : two's-complement negate-if helper used for magnitudes
//                 and for re-applying result signs
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER      = WIDTH_DEF;

    // Widest value cond_neg handles; covers the 2*WIDTH product for WIDTH <= 32.
    localparam int MAX_W = 64;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t PREP = 3'd1;
    localparam state_t CALC = 3'd2;
    localparam state_t FIX  = 3'd3;
    localparam state_t DONE = 3'd4;

    // Returns -x when en is set, x otherwise. Callers zero-extend narrower
    // values and truncate the result; the low bits are still the correct
    // two's-complement negation.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                  input logic             en);
        return en ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_unit_if
// Execute-stage <-> multiply/divide engine handshake.
//   start  : launch an operation (sampled only when the engine is idle/done)
//   sin    : 1 = signed, 0 = unsigned
//   op     : 0 = multiply, 1 = divide
//   in_1   : multiplicand / dividend
//   in_2   : multiplier / divisor
//   busy   : engine is working, stall the pipeline
//   done   : one-cycle pulse, hi_out/lo_out valid
//   hi_out : product high half / remainder
//   lo_out : product low half / quotient
// Modports: master = execute stage, slave = engine.
// -----------------------------------------------------------------------------
interface muldiv_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sin;
    logic             op;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, sin, op, in_1, in_2,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, sin, op, in_1, in_2,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// -----------------------------------------------------------------------------
// muldiv_seq_unit
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register.
// One FSM (IDLE -> PREP -> CALC x WIDTH -> FIX -> DONE) drives a 2*WIDTH
// shift/accumulate datapath: shift-add for multiply, restoring division for
// divide. Signed operations run on magnitudes; FIX re-applies the signs.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : muldiv_seq_unit_if.slave (start/sin/op/in_1/in_2 in,
//            busy/done/hi_out/lo_out out)
//
// Parameter:
//   WIDTH  : operand width (<= 32); one CALC iteration per operand bit
//
// Build option:
//   MULDIV_EARLY_OUT_EN : multiply leaves CALC as soon as the remaining
//                         multiplier bits are zero; a zero multiplier skips
//                         CALC entirely. Results are identical either way.
// -----------------------------------------------------------------------------
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_seq_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t             state;
    logic               sin_q;
    logic               op_q;
    logic [WIDTH-1:0]   in_1_q;
    logic [WIDTH-1:0]   in_2_q;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated (dividend sign)
    logic [2*WIDTH-1:0] acc;       // mult: running product; div: {remainder, quotient}
    logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]   b_reg;     // mult: multiplier, shifted right; div: divisor
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               accept;
    logic [WIDTH-1:0]   mag_1;
    logic [WIDTH-1:0]   mag_2;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   b_shift;
    logic               calc_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // A new operation is only taken when no operation is in flight.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    assign bus.busy   = (state == PREP) || (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path first;
        // a missed assignment would infer a latch.
        mag_1 = WIDTH'(cond_neg(MAX_W'(in_1_q), sin_q & in_1_q[WIDTH-1]));
        mag_2 = WIDTH'(cond_neg(MAX_W'(in_2_q), sin_q & in_2_q[WIDTH-1]));

        // Restoring division step: shift {rem, quo} left, trial-subtract the
        // divisor from the widened remainder, keep the difference if it fits.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, b_reg};
        ge       = (rem_sh >= {1'b0, b_reg});
        div_next = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};

        // Shift-add multiply step: add the aligned multiplicand for a set bit.
        mul_next = b_reg[0] ? (acc + mcand) : acc;
        b_shift  = b_reg >> 1;

        calc_last = (count == CNT_W'(WIDTH - 1)) ||
                    (EARLY_OUT && (op_q == OP_MUL) && (b_shift == '0));

        prod_fix = (2*WIDTH)'(cond_neg(MAX_W'(acc), neg_res));
        quo_fix  = WIDTH'(cond_neg(MAX_W'(acc[WIDTH-1:0]), neg_res));
        rem_fix  = WIDTH'(cond_neg(MAX_W'(acc[2*WIDTH-1:WIDTH]), neg_rem));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sin_q   <= 1'b0;
            op_q    <= OP_MUL;
            in_1_q  <= '0;
            in_2_q  <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            b_reg   <= '0;
            count   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                sin_q  <= bus.sin;
                op_q   <= bus.op;
                in_1_q <= bus.in_1;
                in_2_q <= bus.in_2;
            end

            case (state)
                IDLE: begin
                    if (accept) state <= PREP;
                end

                PREP: begin
                    count   <= '0;
                    neg_res <= sin_q & (in_1_q[WIDTH-1] ^ in_2_q[WIDTH-1]);
                    neg_rem <= sin_q & in_1_q[WIDTH-1];
                    b_reg   <= mag_2;
                    if (op_q == OP_DIV) begin
                        acc <= {{WIDTH{1'b0}}, mag_1};
                        if (in_2_q == '0) begin
                            // Divide by zero: no trap, fixed result pattern.
                            hi_q  <= in_1_q;
                            lo_q  <= '1;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, mag_1};
                        state <= (EARLY_OUT && (in_2_q == '0)) ? FIX : CALC;
                    end
                end

                CALC: begin
                    count <= count + 1'b1;
                    if (op_q == OP_DIV) begin
                        acc <= div_next;
                    end else begin
                        acc   <= mul_next;
                        mcand <= mcand << 1;
                        b_reg <= b_shift;
                    end
                    if (calc_last) state <= FIX;
                end

                FIX: begin
                    if (op_q == OP_DIV) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    state <= DONE;
                end

                DONE: begin
                    state <= accept ? PREP : IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
